// File: rtl/spi_pixel_framebuf.sv
// spi_pixel_framebuf: per-channel double-buffered pixel store loaded from SPI
// frames and published to the string drivers on their frame-sync pulse.
//
// Ports:
//   CLK, RST_N        clock (rising edge), async active-low reset
//   SSEL              raw SPI chip select (active low, asynchronous)
//   RX_DATA/RX_READY  received byte and its one-cycle strobe
//   FRAME_SYNC        per-channel latch pulse from the string drivers
//   RD_REQ/RD_CHAN/RD_ADDR -> RD_DATA/RD_VALID   one-cycle-latency pixel read
//   LED_COUNT         published pixel count per channel, channel 0 in the LSBs
//   OVERFLOW          sticky error flag (over-length frame or bad channel)
module spi_pixel_framebuf #(
    parameter int NUM_CHANNELS  = 4,
    parameter int NUM_LEDS      = 256,
    parameter int BYTES_PER_LED = 3
) (
    input  logic                                         CLK,
    input  logic                                         RST_N,
    input  logic                                         SSEL,
    input  logic [7:0]                                   RX_DATA,
    input  logic                                         RX_READY,
    input  logic [NUM_CHANNELS-1:0]                      FRAME_SYNC,
    input  logic                                         RD_REQ,
    input  logic [$clog2(NUM_CHANNELS)-1:0]              RD_CHAN,
    input  logic [$clog2(NUM_LEDS)-1:0]                  RD_ADDR,
    output logic [8*BYTES_PER_LED-1:0]                   RD_DATA,
    output logic                                         RD_VALID,
    output logic [NUM_CHANNELS*($clog2(NUM_LEDS)+1)-1:0] LED_COUNT,
    output logic                                         OVERFLOW
);

    localparam int CW    = $clog2(NUM_CHANNELS);
    localparam int AW    = $clog2(NUM_LEDS);
    localparam int NW    = AW + 1;
    localparam int WW    = 8 * BYTES_PER_LED;
    localparam int BW    = $clog2(BYTES_PER_LED);
    localparam int RAW   = CW + 1 + AW;
    localparam int DEPTH = 1 << RAW;

    typedef enum logic [1:0] {IDLE, HDR, PIX, DROP} state_t;

    state_t state, state_nx;

    logic ssel_s1, ssel_s2, ssel_d;
    logic arm_v1, arm_v2, armed;
    logic frame_start, frame_end;

    logic [CW-1:0]           chan;
    logic [NW-1:0]           wr_addr;
    logic [BW-1:0]           byte_idx;
    logic [WW-9:0]           pix_word;
    logic                    overflow;
    logic [NUM_CHANNELS-1:0] bank_sel;
    logic [NUM_CHANNELS-1:0] pending;
    logic [NW-1:0]           back_cnt [NUM_CHANNELS];
    logic [NW-1:0]           led_cnt  [NUM_CHANNELS];

    logic hdr_byte, hdr_ok, pix_byte, addr_full, last_byte;
    logic wr_en, publish;
    logic [RAW-1:0] wr_ram_addr, rd_ram_addr;

    logic          rd_chan_ok, rd_hit;
    logic [CW-1:0] rd_chan_s;
    logic [WW-1:0] rd_q;
    logic          rd_valid, rd_hit_q;

    logic [WW-1:0] mem [DEPTH];

    // Two-flop synchroniser plus an edge register. The arm_v* chain marks
    // when ssel_s2 carries a real post-reset sample; a frame start is only
    // accepted once SSEL has been seen high, so a select held low through
    // reset is never mistaken for a new frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ssel_s1 <= 1'b1;
            ssel_s2 <= 1'b1;
            ssel_d  <= 1'b1;
            arm_v1  <= 1'b0;
            arm_v2  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            ssel_s1 <= SSEL;
            ssel_s2 <= ssel_s1;
            ssel_d  <= ssel_s2;
            arm_v1  <= 1'b1;
            arm_v2  <= arm_v1;
            armed   <= armed | (arm_v2 & ssel_s2);
        end
    end

    assign frame_start = armed & ssel_d & ~ssel_s2;
    assign frame_end   = ~ssel_d & ssel_s2;

    assign hdr_byte  = (state == HDR) && RX_READY
                       && !frame_start && !frame_end;
    assign hdr_ok    = RX_DATA < 8'(NUM_CHANNELS);
    assign pix_byte  = (state == PIX) && RX_READY
                       && !frame_start && !frame_end;
    assign addr_full = wr_addr == NW'(NUM_LEDS);
    assign last_byte = byte_idx == BW'(BYTES_PER_LED - 1);
    assign wr_en     = pix_byte && !addr_full && last_byte;
    assign publish   = (state == PIX) && frame_end;

    assign wr_ram_addr = {chan, ~bank_sel[chan], wr_addr[AW-1:0]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (frame_start) begin
            state_nx = HDR;
        end else if (frame_end && state != IDLE) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nx = IDLE;
                HDR:  if (RX_READY) state_nx = hdr_ok ? PIX : DROP;
                PIX:  state_nx = PIX;
                DROP: state_nx = DROP;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            chan     <= '0;
            wr_addr  <= '0;
            byte_idx <= '0;
            pix_word <= '0;
            overflow <= 1'b0;
            bank_sel <= '0;
            pending  <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                back_cnt[c] <= '0;
                led_cnt[c]  <= '0;
            end
        end else begin
            if (hdr_byte) begin
                if (hdr_ok) begin
                    chan     <= RX_DATA[CW-1:0];
                    wr_addr  <= '0;
                    byte_idx <= '0;
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (pix_byte) begin
                if (addr_full) begin
                    overflow <= 1'b1;
                end else if (last_byte) begin
                    wr_addr  <= wr_addr + NW'(1);
                    byte_idx <= '0;
                end else begin
                    pix_word <= {pix_word[WW-17:0], RX_DATA};
                    byte_idx <= byte_idx + BW'(1);
                end
            end
            // A publish to a channel wins over its sync in the same cycle;
            // the swap then waits for the next pulse.
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (publish && chan == CW'(c)) begin
                    back_cnt[c] <= wr_addr;
                    pending[c]  <= 1'b1;
                end else if (FRAME_SYNC[c] && pending[c]) begin
                    bank_sel[c] <= ~bank_sel[c];
                    led_cnt[c]  <= back_cnt[c];
                    pending[c]  <= 1'b0;
                end
            end
        end
    end

    if ((1 << CW) == NUM_CHANNELS) begin : g_ch_full
        assign rd_chan_ok = 1'b1;
        assign rd_chan_s  = RD_CHAN;
    end else begin : g_ch_part
        assign rd_chan_ok = {1'b0, RD_CHAN} < (CW + 1)'(NUM_CHANNELS);
        assign rd_chan_s  = rd_chan_ok ? RD_CHAN : '0;
    end

    assign rd_hit      = rd_chan_ok && ({1'b0, RD_ADDR} < led_cnt[rd_chan_s]);
    assign rd_ram_addr = {rd_chan_s, bank_sel[rd_chan_s], RD_ADDR};

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ram_addr] <= {pix_word, RX_DATA};
        rd_q <= mem[rd_ram_addr];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_valid <= 1'b0;
            rd_hit_q <= 1'b0;
        end else begin
            rd_valid <= RD_REQ;
            rd_hit_q <= RD_REQ & rd_hit;
        end
    end

    // RAM is never cleared; out-of-range reads are masked to zero instead.
    assign RD_DATA  = rd_hit_q ? rd_q : '0;
    assign RD_VALID = rd_valid;
    assign OVERFLOW = overflow;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_cnt
        assign LED_COUNT[g*NW +: NW] = led_cnt[g];
    end

endmodule

// File: tb/tb_spi_pixel_framebuf.sv
// tb_spi_pixel_framebuf: directed bench for spi_pixel_framebuf with
// NUM_CHANNELS=4, NUM_LEDS=4, BYTES_PER_LED=3.
module tb_spi_pixel_framebuf;

    localparam int NC  = 4;
    localparam int NL  = 4;
    localparam int BPL = 3;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          SSEL = 1'b1;
    logic [7:0]    RX_DATA = '0;
    logic          RX_READY = 1'b0;
    logic [NC-1:0] FRAME_SYNC = '0;
    logic          RD_REQ = 1'b0;
    logic [1:0]    RD_CHAN = '0;
    logic [1:0]    RD_ADDR = '0;
    logic [23:0]   RD_DATA;
    logic          RD_VALID;
    logic [11:0]   LED_COUNT;
    logic          OVERFLOW;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    spi_pixel_framebuf #(
        .NUM_CHANNELS (NC),
        .NUM_LEDS     (NL),
        .BYTES_PER_LED(BPL)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .SSEL      (SSEL),
        .RX_DATA   (RX_DATA),
        .RX_READY  (RX_READY),
        .FRAME_SYNC(FRAME_SYNC),
        .RD_REQ    (RD_REQ),
        .RD_CHAN   (RD_CHAN),
        .RD_ADDR   (RD_ADDR),
        .RD_DATA   (RD_DATA),
        .RD_VALID  (RD_VALID),
        .LED_COUNT (LED_COUNT),
        .OVERFLOW  (OVERFLOW)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_DATA  = b;
        RX_READY = 1'b1;
        tick();
        RX_READY = 1'b0;
        tick();
    endtask

    task automatic send_pix(input logic [23:0] p);
        send_byte(p[23:16]);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
    endtask

    task automatic frame_begin();
        SSEL = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame_finish();
        SSEL = 1'b1;
        repeat (4) tick();
    endtask

    task automatic sync(input logic [NC-1:0] m);
        FRAME_SYNC = m;
        tick();
        FRAME_SYNC = '0;
        tick();
    endtask

    task automatic rd(input string tag, input int ch, input int a,
                      input logic [23:0] exp);
        RD_CHAN = 2'(ch);
        RD_ADDR = 2'(a);
        RD_REQ  = 1'b1;
        tick();
        RD_REQ  = 1'b0;
        chk({tag, "_valid"}, 64'(RD_VALID), 64'd1);
        chk(tag, 64'(RD_DATA), 64'(exp));
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ovf", 64'(OVERFLOW), 64'd0);
        chk("rst_valid", 64'(RD_VALID), 64'd0);
        chk("rst_data", 64'(RD_DATA), 64'd0);
        chk("rst_cnt", 64'(LED_COUNT), 64'd0);
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (5) tick();

        // Basic write and publish on channel 1
        frame_begin();
        send_byte(8'h01);
        send_pix(24'h112233);
        send_pix(24'h445566);
        frame_finish();
        chk("pre_sync_cnt", 64'(LED_COUNT), 64'h000);
        rd("pre_sync_rd", 1, 0, 24'h0);
        sync(4'b0010);
        chk("pub_cnt", 64'(LED_COUNT), 64'h010);
        rd("pub_a0", 1, 0, 24'h112233);
        rd("pub_a1", 1, 1, 24'h445566);
        rd("pub_a2", 1, 2, 24'h000000);
        tick();
        chk("idle_valid", 64'(RD_VALID), 64'd0);
        chk("pub_ovf", 64'(OVERFLOW), 64'd0);

        // Double buffering
        frame_begin();
        send_byte(8'h01);
        send_pix(24'hAABBCC);
        frame_finish();
        rd("db_hold", 1, 0, 24'h112233);
        chk("db_hold_cnt", 64'(LED_COUNT), 64'h010);
        sync(4'b0010);
        rd("db_swap", 1, 0, 24'hAABBCC);
        rd("db_swap_a1", 1, 1, 24'h000000);
        chk("db_cnt", 64'(LED_COUNT), 64'h008);

        // Sync without pending has no effect
        sync(4'b0010);
        chk("nopend_cnt", 64'(LED_COUNT), 64'h008);
        rd("nopend_rd", 1, 0, 24'hAABBCC);

        // Over-length frame on channel 2
        frame_begin();
        send_byte(8'h02);
        send_pix(24'h010203);
        send_pix(24'h040506);
        send_pix(24'h070809);
        send_pix(24'h0A0B0C);
        chk("full_noovf", 64'(OVERFLOW), 64'd0);
        send_pix(24'h0D0E0F);
        send_byte(8'h10);
        send_byte(8'h11);
        chk("full_ovf", 64'(OVERFLOW), 64'd1);
        frame_finish();
        sync(4'b0100);
        chk("full_cnt", 64'(LED_COUNT), 64'h108);
        rd("full_a3", 2, 3, 24'h0A0B0C);
        rd("full_a0", 2, 0, 24'h010203);

        // Partial trailing pixel on channel 3
        frame_begin();
        send_byte(8'h03);
        send_pix(24'h212223);
        send_byte(8'h24);
        send_byte(8'h25);
        frame_finish();
        sync(4'b1000);
        chk("part_cnt", 64'(LED_COUNT), 64'h308);
        rd("part_a0", 3, 0, 24'h212223);
        rd("part_a1", 3, 1, 24'h000000);

        // Reset mid-frame, SSEL still low across reset
        frame_begin();
        send_byte(8'h00);
        send_pix(24'h313233);
        send_pix(24'h343536);
        RST_N = 1'b0;
        #2;
        chk("mrst_ovf", 64'(OVERFLOW), 64'd0);
        chk("mrst_cnt", 64'(LED_COUNT), 64'd0);
        chk("mrst_valid", 64'(RD_VALID), 64'd0);
        chk("mrst_data", 64'(RD_DATA), 64'd0);
        tick();
        RST_N = 1'b1;
        repeat (4) tick();
        send_byte(8'h00);
        send_pix(24'h777777);
        frame_finish();
        sync(4'b0001);
        chk("mrst_sync_cnt", 64'(LED_COUNT), 64'd0);
        rd("mrst_rd", 0, 0, 24'h0);
        chk("mrst_ovf2", 64'(OVERFLOW), 64'd0);

        // Bad channel header
        frame_begin();
        send_byte(8'h07);
        send_pix(24'h414243);
        frame_finish();
        chk("bad_ovf", 64'(OVERFLOW), 64'd1);
        sync(4'b1111);
        chk("bad_cnt", 64'(LED_COUNT), 64'd0);
        rd("bad_rd", 0, 0, 24'h0);

        // Frame end and FRAME_SYNC in the same cycle
        frame_begin();
        send_byte(8'h00);
        send_pix(24'h515253);
        frame_finish();
        frame_begin();
        send_byte(8'h00);
        send_pix(24'h616263);
        SSEL = 1'b1;
        tick();
        tick();
        FRAME_SYNC = 4'b0001;
        tick();
        FRAME_SYNC = '0;
        repeat (2) tick();
        chk("sim_noswap_cnt", 64'(LED_COUNT), 64'd0);
        rd("sim_noswap_rd", 0, 0, 24'h0);
        sync(4'b0001);
        chk("sim_swap_cnt", 64'(LED_COUNT), 64'h001);
        rd("sim_swap_rd", 0, 0, 24'h616263);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_pixel_framebuf.md
SPI_PIXEL_FRAMEBUF -- requirements
Module: spi_pixel_framebuf

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of independent LED strings.
REQ-002 Parameter NUM_LEDS, default 256: pixel capacity per channel per bank.
REQ-003 Parameter BYTES_PER_LED, default 3: bytes per pixel; legal values are 3 (GRB) and 4 (GRBW).
REQ-004 CLK  in  1  system clock; all logic is on the rising edge.
REQ-005 RST_N  in  1  reset; asynchronous and active-low.
REQ-006 SSEL  in  1  raw SPI chip select, active-low and asynchronous to CLK.
REQ-007 RX_DATA  in  8  received SPI byte.
REQ-008 RX_READY  in  1  one-cycle strobe; RX_DATA is valid in the same cycle.
REQ-009 FRAME_SYNC  in  NUM_CHANNELS  per-channel one-cycle pulse from the string driver's reset/latch phase.
REQ-010 RD_REQ  in  1  read request.
REQ-011 RD_CHAN  in  clog2(NUM_CHANNELS)  channel to read.
REQ-012 RD_ADDR  in  clog2(NUM_LEDS)  pixel index to read.
REQ-013 RD_DATA  out  8*BYTES_PER_LED  pixel word.
REQ-014 RD_VALID  out  1  RD_DATA is valid.
REQ-015 LED_COUNT  out  NUM_CHANNELS*(clog2(NUM_LEDS)+1)  published pixel count per channel.
REQ-016 OVERFLOW  out  1  sticky flag: an error was detected (over-length frame or bad channel).

Function
REQ-017 SSEL SHALL be synchronised through two flops; a falling edge marks frame start and a rising edge marks frame end.
REQ-018 FSM states SHALL be IDLE, HDR, PIX and DROP.
- IDLE to HDR on frame start.
- Frame start in any other state SHALL restart at HDR.
REQ-019 In HDR, the first RX_READY byte SHALL be the channel index.
- Index < NUM_CHANNELS: go to PIX, clear the write address and byte index.
- Otherwise: go to DROP and set OVERFLOW.
REQ-020 In PIX, bytes SHALL be packed MSB-first into a BYTES_PER_LED-byte word.
- On the last byte, the word SHALL be written to the back bank of the selected channel at the write address.
- The write address SHALL then increment by 1.
REQ-021 When the write address equals NUM_LEDS, further bytes SHALL be discarded and OVERFLOW SHALL be set; the address SHALL NOT wrap.
REQ-022 On frame end in PIX:
- The channel's back count SHALL become the write address (complete pixels only; a partial trailing pixel is discarded).
- The channel's pending flag SHALL be set.
- The FSM SHALL return to IDLE.
REQ-023 On frame end in HDR or DROP, the FSM SHALL return to IDLE and nothing SHALL be published.
REQ-024 On FRAME_SYNC[c] with pending[c] set:
- Swap the front and back banks of c.
- Copy the back count to LED_COUNT[c].
- Clear pending[c].
- Without pending[c] set, the pulse SHALL have no effect.
REQ-025 Frame end and FRAME_SYNC for the same channel in the same cycle: pending SHALL be set and the swap SHALL wait for the next FRAME_SYNC.
REQ-026 A second complete frame to the same channel before its swap SHALL overwrite the back bank and back count; pending stays set.
REQ-027 Reads SHALL always use the front bank; writes SHALL never alter the front bank.
REQ-028 RD_REQ in cycle N SHALL give RD_VALID=1 and RD_DATA in cycle N+1.
- RD_DATA SHALL be 0 when RD_ADDR >= LED_COUNT[RD_CHAN] or RD_CHAN >= NUM_CHANNELS.
- RD_VALID SHALL be 0 in cycles without a prior-cycle RD_REQ.
REQ-029 Storage SHALL be one inferred dual-port RAM of 2*NUM_CHANNELS*NUM_LEDS words.
- Address = {channel, bank, pixel}.
- One write port and one read port.
REQ-030 RX_READY SHALL be ignored in IDLE and DROP.

Reset
REQ-031 While RST_N=0:
- FSM=IDLE, synchroniser flops=1.
- All bank selects, pending flags, back counts and LED_COUNT = 0.
- OVERFLOW=0, RD_VALID=0, RD_DATA=0.
REQ-032 RAM contents SHALL NOT be reset; reads SHALL return 0 after reset because LED_COUNT=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame; nothing from it SHALL be published.
REQ-034 After RST_N deasserts, the first frame start SHALL be recognised only after a clean SSEL high-to-low transition.

Verification
REQ-035 Basic write and publish:
- Stimulus: frame {0x01, 11 22 33, 44 55 66} with 3 bytes per pixel, then FRAME_SYNC[1].
- Response: LED_COUNT[1]=2; reads of ch1 addr0/1/2 return 0x112233, 0x445566, 0.
REQ-036 Double buffering:
- Stimulus: second frame {0x01, AA BB CC} with no FRAME_SYNC.
- Response: reads still return 0x112233; after FRAME_SYNC[1], addr0=0xAABBCC and LED_COUNT[1]=1.
REQ-037 Over-length and partial pixel:
- Stimulus: NUM_LEDS=4, frame of 5 pixels plus 2 stray bytes.
- Response: OVERFLOW=1; after sync LED_COUNT=4; addr3 holds the 4th pixel.
REQ-038 Bad channel:
- Stimulus: header 0x07 with NUM_CHANNELS=4.
- Response: OVERFLOW=1; no RAM write; all LED_COUNT unchanged.
REQ-039 Simultaneous events:
- Stimulus: frame end and FRAME_SYNC[c] in the same cycle.
- Response: no swap; swap occurs on the next FRAME_SYNC[c].
REQ-040 Reset mid-frame:
- Stimulus: RST_N pulsed low after 2 pixels.
- Response: all outputs 0; a subsequent FRAME_SYNC causes no swap.
